state_event_fifo: RTL and testbench
===================================

# state_event_fifo

Downstream monitor for the LED/state-machine top level. It watches the registered 2-bit `state_out` and 4-bit `counter_out` stream and records each state transition as an event word in a small FIFO. The FIFO is drained by a valid/ready consumer, such as a UART formatter or a debug bus. Overflow is tracked with a sticky flag and a saturating drop counter.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `TS_W`, default 16: timestamp width; used only when the timestamp feature is compiled in.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low; all state clears on any rising edge of `clk` where `reset` = 0.
- `state_in` in 2: upstream `state_out`. Encoding: 00 IDLE, 01 COUNT, 10 DISPLAY, 11 RESET_ST.
- `count_in` in 4: upstream `counter_out`.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: consumer accepts the head entry.
- `evt_data` out EW: head entry, first-word fall-through. EW = 8, or 8 + `TS_W` with timestamps.
- `evt_count` out clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when an event is dropped.
- `drop_cnt` out 8: dropped-event count; saturates at 255.
- `clear_ovf` in 1: clears `overflow` and `drop_cnt`.

## Operation
- `prev_state` register resets to 00 (IDLE).
- Each edge compares `state_in` with `prev_state`; any difference is a transition. `prev_state` loads `state_in` every edge.
- Event word, MSB to LSB: {`prev_state`[1:0], `state_in`[1:0], `count_in`[3:0]}. With timestamps, {timestamp, …} is prepended.
- Push occurs on the edge where the transition is sampled.
- Pop occurs on edges where `evt_valid` && `evt_ready`. `evt_ready` while empty has no effect.
- Push and pop both fire when the FIFO is:
  - Not full: both performed; occupancy unchanged.
  - Full: both performed; the push is accepted and nothing is dropped.
- Push with FIFO full and no pop: event discarded, `overflow` ← 1, `drop_cnt` ← min(`drop_cnt`+1, 255).
- `clear_ovf`:
  - Without a drop on the same edge: `overflow` ← 0, `drop_cnt` ← 0.
  - With a drop on the same edge: `overflow` = 1, `drop_cnt` = 1.
- Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `evt_count`.
- Reset mid-operation discards all stored entries and returns to the reset state below.
- Reset values: `evt_valid` 0, `evt_count` 0, `overflow` 0, `drop_cnt` 0. `evt_data` is don't-care while `evt_valid` = 0. Timestamp is 0.

## Timing
- Transition latency: `state_in` changes before edge N → `evt_valid` = 1 and the entry is visible at the head after edge N.
- Pop takes effect at the edge; the next entry, or `evt_valid` = 0, appears after that edge.
- No combinational path from `evt_ready` to `evt_valid`, `evt_data` or `evt_count`. All three derive from registers only.
- `state_in` can change at most once per clock; back-to-back transitions on consecutive edges each produce one event.
- Throughput: one push and one pop per cycle.

## Configuration
- Macro: `STATE_EVT_TIMESTAMP_EN`.
- Defined:
  - A free-running `TS_W`-bit counter resets to 0 and increments every cycle, wrapping from 2^TS_W−1 to 0.
  - Each event captures the counter value of its sampling edge in bits [EW−1:8].
  - EW = 8 + `TS_W`.
- Undefined: no counter; EW = 8; `TS_W` is ignored.

## Test plan
- Reset, then hold `state_in` = 00 for 20 cycles → `evt_valid` = 0, `evt_count` = 0, `overflow` = 0.
- Drive 00→01 with `count_in` = 4'h3, `evt_ready` = 0 → one edge later `evt_valid` = 1, `evt_data`[7:0] = 8'h13. Assert `evt_ready` one cycle → `evt_valid` = 0.
- With `evt_ready` = 0, cycle 01/10 on successive edges for DEPTH+3 transitions:
  - `evt_count` = DEPTH, `overflow` = 1, `drop_cnt` = 3.
  - Draining returns the first DEPTH events in order, confirming pointer wrap.
- FIFO full with simultaneous transition and `evt_ready` = 1 → no drop, `evt_count` stays DEPTH. Pulse `clear_ovf` on an edge that also drops → `overflow` = 1, `drop_cnt` = 1.
- Assert `reset` = 0 for one edge with 5 entries stored → `evt_count` = 0, `evt_valid` = 0. The next transition from 00 logs `prev_state` = 00.
- With `STATE_EVT_TIMESTAMP_EN`: release reset at edge 0, transition sampled at edge 10 → timestamp field = 10. A transition after 2^TS_W+2 edges shows the wrapped value.

Source files
------------

// File: rtl/state_event_fifo.sv
// State-transition event logger: records {prev_state, state, count} words in a FWFT FIFO.
// Optional STATE_EVT_TIMESTAMP_EN prepends a free-running TS_W-bit timestamp to each event.
module state_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16,
`ifdef STATE_EVT_TIMESTAMP_EN
    localparam bit          TS_EN = 1'b1,
`else
    localparam bit          TS_EN = 1'b0,
`endif
    localparam int unsigned EW    = 8 + (TS_EN ? TS_W : 0),
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    state_in,
    input  logic [3:0]    count_in,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [EW-1:0] evt_data,
    output logic [CW-1:0] evt_count,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    input  logic          clear_ovf
);

    logic [1:0]    prev_state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] evt_word;

    logic          push;
    logic          pop;
    logic          full;
    logic          do_push;
    logic          drop;
    logic [CW-1:0] count_nxt;

`ifdef STATE_EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign evt_word = {ts_q, prev_state, state_in, count_in};
`else
    assign evt_word = {prev_state, state_in, count_in};
`endif

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    always_comb begin
        push      = (state_in != prev_state);
        pop       = evt_valid && evt_ready;
        full      = (evt_count == CW'(DEPTH));
        do_push   = push && (!full || pop);
        drop      = push && full && !pop;
        count_nxt = evt_count + CW'(do_push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_state <= 2'b00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_count  <= '0;
            evt_valid  <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            prev_state <= state_in;
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            evt_count <= count_nxt;
            evt_valid <= (count_nxt != '0);
            // A drop on the clearing edge wins: it is the first drop of the new window.
            if (drop) begin
                overflow <= 1'b1;
                if (clear_ovf) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (clear_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    // Storage needs no reset; contents are only visible while evt_valid is set.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= evt_word;
        end
    end

    assign evt_data = mem[rd_ptr];

endmodule

// File: tb/tb_state_event_fifo.sv
// Directed self-checking bench for state_event_fifo; adds a timestamp test when
// STATE_EVT_TIMESTAMP_EN is defined.
module tb_state_event_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 16;
`ifdef STATE_EVT_TIMESTAMP_EN
    localparam int unsigned EW = 8 + TS_W;
`else
    localparam int unsigned EW = 8;
`endif
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic [1:0]    state_in;
    logic [3:0]    count_in;
    logic          evt_valid;
    logic          evt_ready;
    logic [EW-1:0] evt_data;
    logic [CW-1:0] evt_count;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          clear_ovf;

    int checks = 0;
    int errors = 0;

    state_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .state_in  (state_in),
        .count_in  (count_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the other of COUNT/DISPLAY so the next edge sees a transition.
    task automatic toggle();
        state_in = (state_in == 2'd1) ? 2'd2 : 2'd1;
    endtask

    task automatic test_reset();
        repeat (20) tick();
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", evt_valid); end
        checks++; if (evt_count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d want 0", evt_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single();
        state_in = 2'd1;
        count_in = 4'h3;
        tick();
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", evt_valid); end
        checks++; if (evt_data[7:0] !== 8'h13) begin errors++; $display("FAIL single_data got %h want 13", evt_data[7:0]); end
        checks++; if (evt_count !== CW'(1)) begin errors++; $display("FAIL single_count got %0d want 1", evt_count); end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %0b want 0", evt_valid); end
        checks++; if (evt_count !== CW'(0)) begin errors++; $display("FAIL single_pop_count got %0d want 0", evt_count); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        logic [1:0] p;
        logic [1:0] s;
        for (int i = 0; i < DEPTH + 3; i++) begin
            s = (i % 2 == 0) ? 2'd2 : 2'd1;
            p = (i % 2 == 0) ? 2'd1 : 2'd2;
            state_in = s;
            count_in = 4'(i);
            if (i < DEPTH) exp_q.push_back({p, s, 4'(i)});
            tick();
        end
        checks++; if (evt_count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got %0d want %0d", evt_count, DEPTH); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL ovf_drop got %0d want 3", drop_cnt); end
        evt_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_data[7:0] !== exp_q[k]) begin
                errors++;
                $display("FAIL drain_%0d got v=%0b %h want v=1 %h", k, evt_valid, evt_data[7:0], exp_q[k]);
            end
            tick();
        end
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", evt_valid); end
        checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL drain_drop_kept got %0d want 3", drop_cnt); end
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL clear got ovf=%0b drop=%0d want 0 0", overflow, drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            toggle();
            count_in = 4'(i);
            tick();
        end
        checks++; if (evt_count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count got %0d want %0d", evt_count, DEPTH); end
        // first entry: prev 10 -> 01 with count 0
        checks++; if (evt_data[7:0] !== 8'h90) begin errors++; $display("FAIL fill_head got %h want 90", evt_data[7:0]); end
        toggle();
        count_in = 4'hA;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++; if (evt_count !== CW'(DEPTH)) begin errors++; $display("FAIL pushpop_count got %0d want %0d", evt_count, DEPTH); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL pushpop_drop got ovf=%0b drop=%0d want 0 0", overflow, drop_cnt); end
        // second entry: prev 01 -> 10 with count 1
        checks++; if (evt_data[7:0] !== 8'h61) begin errors++; $display("FAIL pushpop_head got %h want 61", evt_data[7:0]); end
    endtask

    task automatic test_clear_with_drop();
        toggle();
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL clr_drop got ovf=%0b drop=%0d want 1 1", overflow, drop_cnt); end
        toggle();
        tick();
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_inc got %0d want 2", drop_cnt); end
    endtask

    task automatic test_saturate();
        repeat (260) begin
            toggle();
            tick();
        end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", drop_cnt); end
        checks++; if (evt_count !== CW'(DEPTH)) begin errors++; $display("FAIL saturate_count got %0d want %0d", evt_count, DEPTH); end
    endtask

    task automatic test_mid_reset();
        reset    = 1'b0;
        state_in = 2'd0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            toggle();
            tick();
        end
        checks++; if (evt_count !== CW'(5)) begin errors++; $display("FAIL five_count got %0d want 5", evt_count); end
        reset    = 1'b0;
        state_in = 2'd1;
        tick();
        checks++; if (evt_count !== CW'(0) || evt_valid !== 1'b0) begin errors++; $display("FAIL midrst got cnt=%0d v=%0b want 0 0", evt_count, evt_valid); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_ovf got ovf=%0b drop=%0d want 0 0", overflow, drop_cnt); end
        reset    = 1'b1;
        count_in = 4'h7;
        tick();
        checks++; if (evt_valid !== 1'b1 || evt_data[7:0] !== 8'h17) begin errors++; $display("FAIL post_rst got v=%0b %h want v=1 17", evt_valid, evt_data[7:0]); end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL post_rst_pop got %0b want 0", evt_valid); end
    endtask

`ifdef STATE_EVT_TIMESTAMP_EN
    task automatic test_timestamp();
        reset    = 1'b0;
        state_in = 2'd0;
        tick();
        reset = 1'b1;
        repeat (10) tick();
        state_in = 2'd1;
        tick();
        checks++; if (evt_data[EW-1:8] !== TS_W'(10)) begin errors++; $display("FAIL ts_10 got %0d want 10", evt_data[EW-1:8]); end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        repeat ((1 << TS_W) - 10) tick();
        state_in = 2'd2;
        tick();
        checks++; if (evt_valid !== 1'b1 || evt_data[EW-1:8] !== TS_W'(2)) begin errors++; $display("FAIL ts_wrap got v=%0b %0d want v=1 2", evt_valid, evt_data[EW-1:8]); end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        state_in  = 2'd0;
        count_in  = 4'd0;
        evt_ready = 1'b0;
        clear_ovf = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_clear_with_drop();
        test_saturate();
        test_mid_reset();
`ifdef STATE_EVT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
